hazard_unit: RTL and testbench
==============================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Interface, clock and reset: `clk`, input, 1 bit, single clock; all state updates on the rising edge.
REQ-002 Interface, clock and reset: `reset`, input, 1 bit; asynchronous, active-low (0 = reset asserted).
REQ-003 Interface, register addresses: `Ra1D`, `Ra2D`, `Ra1E`, `Ra2E`, `WA3E`, `WA3M`, `WA3W`, each input, 4 bits; source and destination register numbers per stage.
REQ-004 Interface, write enables: `RegWriteM` and `RegWriteW`, inputs, 1 bit; `RegWriteM` is already condition-gated by the condition unit.
REQ-005 Interface, load marker: `MemtoRegE`, input, 1 bit; the E-stage instruction is a load.
REQ-006 Interface, PC-write signals: `PCSrcD`, `PCSrcE`, `PCSrcM`, `PCSrcW`, inputs, 1 bit; PC-write pending per stage.
REQ-007 Interface, branch: `BranchTakenE`, input, 1 bit; resolved taken branch from the condition unit.
REQ-008 Interface, vector memory start: `VecMemM`, input, 1 bit; one-cycle pulse when a vector load/store enters M.
REQ-009 Interface, vector length: `VecLenM`, input, 4 bits; beat count, where 1..15 are literal and 0 means 16.
REQ-010 Interface, memory handshake: `MemReadyM`, input, 1 bit; memory accepts or returns one beat this cycle.
REQ-011 Interface, forwarding selects: `ForwardAE`, `ForwardBE`, outputs, 2 bits; 00 = register file, 01 = W result, 10 = M result.
REQ-012 Interface, stalls: `StallF`, `StallD`, `StallE`, `StallM`, outputs, 1 bit each.
REQ-013 Interface, flushes: `FlushD`, `FlushE`, `FlushW`, outputs, 1 bit each; a flush inserts a bubble.
REQ-014 Interface, vector status: `VecBusy` and `VecLastBeat`, outputs, 1 bit; sequencer status.

Function
REQ-015 Forwarding, A operand:
- `ForwardAE` = 10 when `RegWriteM` and `Ra1E==WA3M`.
- Else 01 when `RegWriteW` and `Ra1E==WA3W`.
- Else 00.
- M has priority when both match.
REQ-016 Forwarding, B operand: `ForwardBE` is identical to `ForwardAE` using `Ra2E`.
REQ-017 Load-use: `ldrStall` = `MemtoRegE & ((Ra1D==WA3E) | (Ra2D==WA3E))`.
REQ-018 PC pending: `PCWrPending` = `PCSrcD | PCSrcE | PCSrcM`.
REQ-019 Vector sequencer states: IDLE and BUSY only.
REQ-020 IDLE to BUSY: on `VecMemM`, load the 5-bit counter `beats_left` with `VecLenM` (0 loads 16).
REQ-021 Beat consumption in BUSY: each cycle with `MemReadyM`=1 consumes one beat and decrements `beats_left`.
REQ-022 BUSY to IDLE: taken on the cycle the final beat is consumed (`beats_left==1` and `MemReadyM`=1).
REQ-023 BUSY without handshake: with `MemReadyM`=0, state and counter hold; there is no timeout.
REQ-024 Vector status outputs:
- `VecBusy` = (state==BUSY).
- `VecLastBeat` = BUSY & (`beats_left==1`); Moore-decoded.
REQ-025 Back-to-back vector ops: `VecMemM` asserted while BUSY is ignored; the M stage is stalled, so no legal pipeline produces it.
REQ-026 Busy stall: `vbusy_stall` = BUSY & ~(`VecLastBeat` & `MemReadyM`).
REQ-027 F and D stalls:
- `StallF` = `ldrStall | PCWrPending | vbusy_stall`.
- `StallD` = `ldrStall | vbusy_stall`.
REQ-028 E and M stalls: `StallE` = `StallM` = `vbusy_stall`.
REQ-029 FlushD = `(PCWrPending | PCSrcW | BranchTakenE) & ~vbusy_stall`.
REQ-030 FlushE = `(ldrStall | BranchTakenE) & ~vbusy_stall`; flushes are deferred, not lost, because E is frozen while the stall holds.
REQ-031 FlushW = `vbusy_stall`, so no duplicate W retirement occurs while M is held.
REQ-032 Latency: all stall, flush and forward outputs are combinational from inputs plus current state; the sequencer adds zero cycles beyond the `VecLen` handshaken beats.

Reset
REQ-033 Asynchronous clear: `reset`=0 forces state to IDLE and `beats_left` to 0 immediately, including mid-operation.
REQ-034 Outputs while reset is asserted:
- `FlushD`=`FlushE`=`FlushW`=1.
- All stalls 0, `ForwardAE`=`ForwardBE`=00, `VecBusy`=`VecLastBeat`=0.
REQ-035 Reset release: the first rising edge after `reset` goes to 1 sees IDLE; a pending `VecMemM` on that edge is accepted.

Structure
REQ-036 Shared package `pipeline_pkg` holds:
- `vseq_state_t` (IDLE, BUSY).
- `fwd_sel_t` constants FWD_RF=00, FWD_W=01, FWD_M=10.
- `VEC_MAX_BEATS`=16.
REQ-037 Sub-module: the FSM and beat counter form one sub-module, `vec_mem_seq`, exporting `VecBusy`, `VecLastBeat` and `vbusy_stall`; forwarding and stall/flush logic stay in the top module.

Verification
REQ-038 Forwarding priority: `Ra1E`=3, `WA3M`=3, `WA3W`=3, `RegWriteM`=`RegWriteW`=1 -> `ForwardAE`=10; then `RegWriteM`=0 -> `ForwardAE`=01.
REQ-039 Load-use: `MemtoRegE`=1, `WA3E`=5, `Ra2D`=5 -> `StallF`=`StallD`=`FlushE`=1 for exactly that cycle, with `StallE`=0.
REQ-040 Vector handshake: `VecMemM` pulse with `VecLenM`=4, `MemReadyM` pattern 1,0,1,1,1 ->
- BUSY for 5 cycles.
- `VecLastBeat` in cycle 5 only.
- `StallE`=1 in cycles 1-4 and 0 in cycle 5.
- IDLE after cycle 5.
REQ-041 Zero length: `VecLenM`=0 with `MemReadyM` held at 1 -> exactly 16 BUSY cycles; `beats_left` is never observed as 0 while BUSY.
REQ-042 Branch during busy: `BranchTakenE`=1 held during a `VecLenM`=2 op with `MemReadyM` 0,1,1 -> `FlushE`=0 for the first two cycles and `FlushE`=1 on the final-beat cycle.
REQ-043 Reset mid-op: `reset`=0 asserted mid-op with `beats_left`=7 -> `VecBusy`=0 and all flushes=1 without waiting for a clock edge; after release, a fresh `VecLenM`=1 op completes in 1 handshaken cycle.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline types for the hazard unit and its vector memory sequencer.
//   vseq_state_t  : sequencer states (IDLE, BUSY)
//   fwd_sel_t     : operand forwarding select encoding
//   VEC_MAX_BEATS : beat count represented by a VecLen field of 0
//   fwd_sel()     : forwarding select for one E-stage source operand
package pipeline_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } vseq_state_t;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    localparam int VEC_MAX_BEATS = 16;

    // M result is younger than W result, so it wins when both match.
    function automatic fwd_sel_t fwd_sel(
        input logic [3:0] ra,
        input logic [3:0] wa_m,
        input logic [3:0] wa_w,
        input logic       we_m,
        input logic       we_w
    );
        if (we_m && (ra == wa_m)) begin
            return FWD_M;
        end else if (we_w && (ra == wa_w)) begin
            return FWD_W;
        end else begin
            return FWD_RF;
        end
    endfunction

endpackage

// File: rtl/vec_mem_seq.sv
// Vector memory beat sequencer. Counts handshaken beats of a vector
// load/store sitting in M and holds the pipeline until the final beat.
//   clk, rst_n      : clock, asynchronous active-low reset
//   vec_mem_i       : start pulse (ignored while BUSY)
//   vec_len_i       : beat count, 0 means VEC_MAX_BEATS
//   mem_ready_i     : one beat accepted/returned this cycle
//   vec_busy_o      : sequencer is BUSY (registered)
//   vec_last_beat_o : BUSY with exactly one beat left (registered)
//   vbusy_stall_o   : hold the pipeline this cycle
//   state_o         : current sequencer state, for observation
// Handshake: a beat is consumed on every rising edge where the sequencer
// is BUSY and mem_ready_i is 1; without mem_ready_i everything holds.
module vec_mem_seq
    import pipeline_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vec_mem_i,
    input  logic [3:0]  vec_len_i,
    input  logic        mem_ready_i,
    output logic        vec_busy_o,
    output logic        vec_last_beat_o,
    output logic        vbusy_stall_o,
    output vseq_state_t state_o
);

    vseq_state_t state_q;
    logic [4:0]  beats_left_q;
    logic [4:0]  beats_load_d;
    logic        busy_q;
    logic        last_q;

    assign beats_load_d = (vec_len_i == 4'd0) ? 5'(VEC_MAX_BEATS) : {1'b0, vec_len_i};

    // Status flags are registered alongside the state so they stay pure
    // Moore outputs; last_q anticipates the count reaching 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            beats_left_q <= 5'd0;
            busy_q       <= 1'b0;
            last_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (vec_mem_i) begin
                        state_q      <= BUSY;
                        beats_left_q <= beats_load_d;
                        busy_q       <= 1'b1;
                        last_q       <= (beats_load_d == 5'd1);
                    end
                end
                BUSY: begin
                    if (mem_ready_i) begin
                        if (beats_left_q == 5'd1) begin
                            state_q      <= IDLE;
                            beats_left_q <= 5'd0;
                            busy_q       <= 1'b0;
                            last_q       <= 1'b0;
                        end else begin
                            beats_left_q <= beats_left_q - 5'd1;
                            last_q       <= (beats_left_q == 5'd2);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign vec_busy_o      = busy_q;
    assign vec_last_beat_o = last_q;
    // The final-beat cycle lets the pipeline advance, so the op costs
    // exactly its handshaken beats and nothing extra.
    assign vbusy_stall_o   = busy_q & ~(last_q & mem_ready_i);
    assign state_o         = state_q;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: operand forwarding, load-use and PC-write stalls,
// branch flushes, and the vector memory sequencer hold.
//   clk, reset                  : clock, asynchronous active-low reset
//   Ra1D/Ra2D, Ra1E/Ra2E        : source registers in D and E
//   WA3E/WA3M/WA3W              : destination registers in E, M, W
//   RegWriteM/RegWriteW         : destination write enables
//   MemtoRegE                   : E-stage instruction is a load
//   PCSrcD/E/M/W                : PC write pending per stage
//   BranchTakenE                : resolved taken branch
//   VecMemM/VecLenM/MemReadyM   : vector memory op start, length, handshake
//   ForwardAE/ForwardBE         : forwarding selects (fwd_sel_t encoding)
//   StallF/D/E/M, FlushD/E/W    : pipeline stall and flush controls
//   VecBusy/VecLastBeat         : sequencer status
// All outputs are combinational from inputs plus sequencer state. While
// reset is held every flush is forced on and everything else is quiet.
module hazard_unit
    import pipeline_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Ra1D,
    input  logic [3:0] Ra2D,
    input  logic [3:0] Ra1E,
    input  logic [3:0] Ra2E,
    input  logic [3:0] WA3E,
    input  logic [3:0] WA3M,
    input  logic [3:0] WA3W,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       MemtoRegE,
    input  logic       PCSrcD,
    input  logic       PCSrcE,
    input  logic       PCSrcM,
    input  logic       PCSrcW,
    input  logic       BranchTakenE,
    input  logic       VecMemM,
    input  logic [3:0] VecLenM,
    input  logic       MemReadyM,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       StallM,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushW,
    output logic       VecBusy,
    output logic       VecLastBeat
);

    logic        ldr_stall;
    logic        pc_wr_pending;
    logic        vbusy_stall;
    vseq_state_t vseq_state;

    vec_mem_seq u_seq (
        .clk             (clk),
        .rst_n           (reset),
        .vec_mem_i       (VecMemM),
        .vec_len_i       (VecLenM),
        .mem_ready_i     (MemReadyM),
        .vec_busy_o      (VecBusy),
        .vec_last_beat_o (VecLastBeat),
        .vbusy_stall_o   (vbusy_stall),
        .state_o         (vseq_state)
    );

    assign ldr_stall     = MemtoRegE & ((Ra1D == WA3E) | (Ra2D == WA3E));
    assign pc_wr_pending = PCSrcD | PCSrcE | PCSrcM;

    assign ForwardAE = reset ? fwd_sel(Ra1E, WA3M, WA3W, RegWriteM, RegWriteW) : FWD_RF;
    assign ForwardBE = reset ? fwd_sel(Ra2E, WA3M, WA3W, RegWriteM, RegWriteW) : FWD_RF;

    assign StallF = reset & (ldr_stall | pc_wr_pending | vbusy_stall);
    assign StallD = reset & (ldr_stall | vbusy_stall);
    assign StallE = reset & vbusy_stall;
    assign StallM = reset & vbusy_stall;

    // D/E flushes wait out a vector hold: E is frozen, so the flush
    // condition is still present on the cycle the hold releases.
    assign FlushD = ~reset | ((pc_wr_pending | PCSrcW | BranchTakenE) & ~vbusy_stall);
    assign FlushE = ~reset | ((ldr_stall | BranchTakenE) & ~vbusy_stall);
    // W is bubbled while M is held so the held instruction retires once.
    assign FlushW = ~reset | vbusy_stall;

    a_busy_matches_state: assert property (
        @(posedge clk) disable iff (!reset) VecBusy == (vseq_state == BUSY)
    );

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;

  localparam int W = 13;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Ra1D, Ra2D, Ra1E, Ra2E, WA3E, WA3M, WA3W;
  logic       RegWriteM, RegWriteW, MemtoRegE;
  logic       PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE;
  logic       VecMemM, MemReadyM;
  logic [3:0] VecLenM;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic       VecBusy, VecLastBeat;

  // bit map: 12:11 FAE, 10:9 FBE, 8 StallF, 7 StallD, 6 StallE, 5 StallM,
  //          4 FlushD, 3 FlushE, 2 FlushW, 1 VecBusy, 0 VecLastBeat
  logic [W-1:0] dut_obs;
  assign dut_obs = {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
                    FlushD, FlushE, FlushW, VecBusy, VecLastBeat};

  logic [W-1:0] exp_q[$];
  logic [W-1:0] o;
  int n_vec = 0;
  int n_err = 0;
  bit m_busy;
  int m_left;

  hazard_unit dut (
    .clk(clk), .reset(reset),
    .Ra1D(Ra1D), .Ra2D(Ra2D), .Ra1E(Ra1E), .Ra2E(Ra2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
    .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
    .BranchTakenE(BranchTakenE), .VecMemM(VecMemM), .VecLenM(VecLenM),
    .MemReadyM(MemReadyM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .VecBusy(VecBusy), .VecLastBeat(VecLastBeat)
  );

  // clock/reset block
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [3:0] ra);
    if (RegWriteM && ra == WA3M) return 2'b10;
    if (RegWriteW && ra == WA3W) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [W-1:0] model_out();
    logic ldr, pcp, last, vs;
    if (!reset) return 13'b0_0000_0001_1100;
    ldr  = MemtoRegE && (Ra1D == WA3E || Ra2D == WA3E);
    pcp  = PCSrcD || PCSrcE || PCSrcM;
    last = m_busy && (m_left == 1);
    vs   = m_busy && !(last && MemReadyM);
    return {ref_fwd(Ra1E), ref_fwd(Ra2E),
            ldr | pcp | vs, ldr | vs, vs, vs,
            (pcp | PCSrcW | BranchTakenE) & ~vs,
            (ldr | BranchTakenE) & ~vs,
            vs, m_busy, last};
  endfunction

  function automatic void model_edge();
    if (!m_busy) begin
      if (VecMemM) begin
        m_busy = 1'b1;
        m_left = (VecLenM == 4'd0) ? 16 : int'(VecLenM);
      end
    end else if (MemReadyM) begin
      m_left--;
      if (m_left == 0) m_busy = 1'b0;
    end
  endfunction

  // driver: inputs are set at the falling edge before calling
  task automatic step(input string tag, output logic [W-1:0] obs);
    logic [W-1:0] e;
    if (!reset) begin
      m_busy = 1'b0;
      m_left = 0;
    end
    exp_q.push_back(model_out());
    #1;
    obs = dut_obs;
    e = exp_q.pop_front();
    check_vec(tag, obs, e);
    @(posedge clk);
    if (reset) model_edge();
    @(negedge clk);
  endtask

  task automatic set_idle();
    {Ra1D, Ra2D, Ra1E, Ra2E} = '0;
    WA3E = 4'd15; WA3M = 4'd14; WA3W = 4'd13;
    {RegWriteM, RegWriteW, MemtoRegE} = '0;
    {PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE} = '0;
    VecMemM = 1'b0; VecLenM = 4'd0; MemReadyM = 1'b0;
  endtask

  initial begin
    int cyc, last_at;
    reset = 1'b0;
    set_idle();
    m_busy = 1'b0;
    m_left = 0;
    @(negedge clk);
    step("reset0", o);
    check_vec("reset_outputs", o, 13'h001C);
    step("reset1", o);
    reset = 1'b1;
    step("idle", o);

    // forwarding priority
    Ra1E = 4'd3; WA3M = 4'd3; WA3W = 4'd3; RegWriteM = 1'b1; RegWriteW = 1'b1;
    step("fwd_both", o);
    check_vec("fwdA_m_prio", {11'b0, o[12:11]}, 13'd2);
    RegWriteM = 1'b0;
    step("fwd_w", o);
    check_vec("fwdA_w", {11'b0, o[12:11]}, 13'd1);
    set_idle();

    // load-use
    MemtoRegE = 1'b1; WA3E = 4'd5; Ra2D = 4'd5;
    step("ldr", o);
    check_vec("ldr_stall", {9'b0, o[8], o[7], o[3], o[6]}, 13'b1110);
    set_idle();
    step("ldr_gone", o);
    check_vec("ldr_cleared", {9'b0, o[8], o[7], o[3], o[6]}, 13'b0000);

    // vector handshake, len 4, ready 1,0,1,1,1
    VecMemM = 1'b1; VecLenM = 4'd4;
    step("v4_start", o);
    VecMemM = 1'b0;
    for (int i = 0; i < 5; i++) begin
      logic [4:0] rdy;
      rdy = 5'b11101;
      MemReadyM = rdy[i];
      step("v4_beat", o);
      check_vec("v4_busy_last_stallE", {10'b0, o[1], o[0], o[6]},
                {10'b0, 1'b1, (i == 4), (i != 4)});
    end
    MemReadyM = 1'b0;
    step("v4_after", o);
    check_vec("v4_idle", {12'b0, o[1]}, 13'd0);

    // zero length means 16 beats
    VecMemM = 1'b1; VecLenM = 4'd0;
    step("v16_start", o);
    VecMemM = 1'b0; MemReadyM = 1'b1;
    cyc = 0; last_at = -1;
    for (int i = 0; i < 40; i++) begin
      step("v16_beat", o);
      if (o[0]) last_at = cyc + 1;
      if (!o[1]) break;
      cyc++;
    end
    check_vec("v16_busy_cycles", 13'(cyc), 13'd16);
    check_vec("v16_last_pos", 13'(last_at), 13'd16);
    MemReadyM = 1'b0;

    // branch held during a 2-beat op, ready 0,1,1
    VecMemM = 1'b1; VecLenM = 4'd2;
    step("vbr_start", o);
    VecMemM = 1'b0; BranchTakenE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      MemReadyM = (i != 0);
      step("vbr_beat", o);
      check_vec("vbr_flushE", {12'b0, o[3]}, {12'b0, (i == 2)});
    end
    set_idle();

    // asynchronous reset mid-op with 7 beats left
    VecMemM = 1'b1; VecLenM = 4'd10;
    step("vrst_start", o);
    VecMemM = 1'b0; MemReadyM = 1'b1;
    for (int i = 0; i < 3; i++) step("vrst_beat", o);
    #2 reset = 1'b0;
    #1 check_vec("async_reset", {9'b0, dut_obs[1], dut_obs[4], dut_obs[3], dut_obs[2]}, 13'b0111);
    step("vrst_held", o);
    reset = 1'b1;
    MemReadyM = 1'b0; VecMemM = 1'b1; VecLenM = 4'd1;
    step("v1_start", o);
    VecMemM = 1'b0; MemReadyM = 1'b1;
    step("v1_beat", o);
    check_vec("v1_last", {10'b0, o[1], o[0], o[6]}, 13'b110);
    step("v1_done", o);
    check_vec("v1_idle", {12'b0, o[1]}, 13'd0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      Ra1D = 4'($urandom_range(0, 3)); Ra2D = 4'($urandom_range(0, 3));
      Ra1E = 4'($urandom_range(0, 3)); Ra2E = 4'($urandom_range(0, 3));
      WA3E = 4'($urandom_range(0, 3)); WA3M = 4'($urandom_range(0, 3));
      WA3W = 4'($urandom_range(0, 3));
      RegWriteM = 1'($urandom_range(0, 1)); RegWriteW = 1'($urandom_range(0, 1));
      MemtoRegE = ($urandom_range(0, 3) == 0);
      PCSrcD = ($urandom_range(0, 5) == 0); PCSrcE = ($urandom_range(0, 5) == 0);
      PCSrcM = ($urandom_range(0, 5) == 0); PCSrcW = ($urandom_range(0, 5) == 0);
      BranchTakenE = ($urandom_range(0, 4) == 0);
      VecMemM = ($urandom_range(0, 5) == 0);
      VecLenM = 4'($urandom_range(0, 15));
      MemReadyM = ($urandom_range(0, 2) != 0);
      reset = ($urandom_range(0, 99) != 0);
      step("rand", o);
    end
    reset = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
